uart_tx_buffer: RTL

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_tx_buffer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/uart_tx_buffer.sv
// Byte FIFO in front of a UART transmitter: buffers writes and hands bytes one at a
// time to the transmitter with a send/busy handshake, busy arriving from a slower domain.
module uart_tx_buffer #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      wr_en,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_send,
    input  logic                      tx_busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQUEST   = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr_reg, wr_ptr_reg;
    logic [AW:0]           count_reg, count_next;
    logic                  full_reg, empty_reg, overflow_reg;
    logic                  tx_send_reg;
    logic [DATA_WIDTH-1:0] tx_data_reg;
    logic                  busy_meta_reg, busy_s_reg;
    logic                  wr_ok, pop;

    // Writes while full are dropped; reset also blocks the storage write.
    assign wr_ok = wr_en && !full_reg && !reset;

    // Storage is deliberately left out of reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty_reg) begin
                    pop        = 1'b1;
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                if (busy_s_reg) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!busy_s_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            empty_reg     <= 1'b1;
            full_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            tx_send_reg   <= 1'b0;
            tx_data_reg   <= '0;
            busy_meta_reg <= 1'b0;
            busy_s_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            busy_meta_reg <= tx_busy;
            busy_s_reg    <= busy_meta_reg;
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            // The head byte is captured at pop and held until the next pop.
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                tx_data_reg <= mem[rd_ptr_reg];
            end
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == (AW+1)'(DEPTH));
            if (wr_en && full_reg) begin
                overflow_reg <= 1'b1;
            end
            tx_send_reg <= (state_next == REQUEST);
        end
    end

    assign full     = full_reg;
    assign empty    = empty_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign tx_data  = tx_data_reg;
    assign tx_send  = tx_send_reg;

endmodule
